// File: rtl/aes_pkg.sv
// Shared types and constants for the AES request arbiter.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/aes_rr_grant.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping around, returned as a one-hot grant plus its index.
module aes_rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  logic [IDW-1:0] k;

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = IDW'((int'(ptr_i) + off) % NUM_REQ);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin scheduler sharing one AES core between NUM_REQ requesters,
// with a watchdog that aborts jobs whose core never reports valid.
module aes_req_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                           AES_clk,
  input  logic                           AES_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_data,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [AES_BLOCK_W-1:0]         resp_data,
  output logic [IDW-1:0]                 resp_id,
  output logic                           resp_err,
  output logic                           core_en,
  output logic [AES_BLOCK_W-1:0]         core_data_in,
  output logic [AES_BLOCK_W-1:0]         core_key_in,
  input  logic [AES_BLOCK_W-1:0]         core_data_out,
  input  logic                           core_data_out_valid,
  output logic                           busy
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  arb_state_e             state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic [AES_BLOCK_W-1:0] op_data_q, op_data_d;
  logic [AES_BLOCK_W-1:0] op_key_q, op_key_d;
  logic [AES_BLOCK_W-1:0] resp_data_q, resp_data_d;
  logic [IDW-1:0]         resp_id_q, resp_id_d;
  logic                   resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0]     gnt;
  logic [IDW-1:0]         gnt_idx;
  logic                   gnt_any;
  logic [AES_BLOCK_W-1:0] sel_data, sel_key;

  aes_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_grant (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Route the winning requester's plaintext and key toward the operand registers.
  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_data = req_data[i*AES_BLOCK_W +: AES_BLOCK_W];
        sel_key  = req_key[i*AES_BLOCK_W +: AES_BLOCK_W];
      end
    end
  end

  // Next-state logic: grant in IDLE, run/watchdog, hold response, one-cycle gap.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    wd_d        = wd_q;
    op_data_d   = op_data_q;
    op_key_d    = op_key_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        // req_ready mirrors the grant, so any pick is a completed handshake.
        if (gnt_any) begin
          op_data_d = sel_data;
          op_key_d  = sel_key;
          resp_id_d = gnt_idx;
          rr_ptr_d  = IDW'((int'(gnt_idx) + 1) % NUM_REQ);
          wd_d      = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        // A core result in the expiry cycle still counts as success.
        if (core_data_out_valid) begin
          resp_data_d = core_data_out;
          resp_err_d  = 1'b0;
          state_d     = RESP;
        end else if (wd_q == WD_LAST) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, watchdog, operand and response registers.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      wd_q        <= '0;
      op_data_q   <= '0;
      op_key_q    <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_q        <= wd_d;
      op_data_q   <= op_data_d;
      op_key_q    <= op_key_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready    = (state_q == IDLE) ? gnt : '0;
  assign core_en      = (state_q == RUN);
  assign core_data_in = op_data_q;
  assign core_key_in  = op_key_q;
  assign resp_valid   = (state_q == RESP);
  assign resp_data    = resp_data_q;
  assign resp_id      = resp_id_q;
  assign resp_err     = resp_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin scheduler that shares one AES_top encryption core between NUM_REQ independent requesters. Accepts one plaintext/key job per valid/ready handshake, holds the core enable and operands stable for the whole encryption, and returns the ciphertext tagged with the requester ID. A watchdog aborts jobs whose core never reports valid. Sits between the requester interconnect and the AES_top instance.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- TIMEOUT, 64: max RUN cycles before abort (must exceed core latency).
- IDW, $clog2(NUM_REQ): response ID width (derived, not overridden).
- AES_clk  in  1  sole clock, rising edge.
- AES_rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester job pending.
- req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit high.
- req_data  in  NUM_REQ*128  plaintexts; requester i at [128*i +: 128].
- req_key  in  NUM_REQ*128  keys, same packing.
- resp_valid  out  1  result available.
- resp_ready  in  1  downstream accepts result.
- resp_data  out  128  ciphertext (0 on error).
- resp_id  out  IDW  index of requester that owns the result.
- resp_err  out  1  1 = job aborted by watchdog.
- core_en  out  1  drives AES_top AES_en.
- core_data_in  out  128  drives AES_data_in.
- core_key_in  out  128  drives AES_key_in.
- core_data_out  in  128  from AES_data_out.
- core_data_out_valid  in  1  from AES_data_out_valid.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, RUN, RESP, GAP.
- IDLE: if any req_valid, grant the first asserted requester at or after rr_ptr (wrapping); req_ready of that requester high combinationally that cycle. On handshake latch data/key/id into operand registers, rr_ptr <= winner+1 mod NUM_REQ, go RUN. No req_valid: stay IDLE, all req_ready low.
- RUN: core_en=1, core_data_in/core_key_in = latched operands, unchanged every cycle. Watchdog counts from 0. On core_data_out_valid: capture core_data_out, resp_err=0, go RESP. Counter reaching TIMEOUT-1 with no valid: resp_data=0, resp_err=1, go RESP. Valid and timeout in same cycle: valid wins (err=0).
- RESP: core_en=0, resp_valid=1; resp_data/id/err stable until resp_ready. On handshake go GAP.
- GAP: one cycle, core_en=0, no grant; go IDLE. Guarantees core_en low ≥2 cycles between jobs.
- core_data_out_valid outside RUN ignored.
- req_ready never asserted outside IDLE; requesters may drop req_valid at any time before handshake without side effects.
- Operand registers keep last values when idle; core_en is the only qualifier.

## Timing
- Reset values: state IDLE, rr_ptr 0, req_ready 0, resp_valid 0, resp_data 0, resp_id 0, resp_err 0, core_en 0, core_data_in 0, core_key_in 0, busy 0, watchdog 0.
- Reset mid-job: next edge returns to IDLE, core_en drops, pending result discarded, no response issued.
- Handshake at cycle t -> core_en high from t+1.
- Core valid at cycle v -> resp_valid high from v+1.
- resp_ready high in first RESP cycle -> GAP at next edge, IDLE one cycle later; earliest next grant 2 cycles after response handshake.
- Timeout: core_en high exactly TIMEOUT cycles, resp_valid on cycle t+1+TIMEOUT.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.

## Structure
- Shared package aes_pkg: state enum (IDLE, RUN, RESP, GAP), AES_BLOCK_W=128 constant.
- One sub-module: aes_rr_grant (combinational round-robin pick: req vector + pointer -> one-hot grant + index). FSM, operand/response registers and watchdog stay in aes_req_arbiter.
- Bench uses a behavioural AES_top model with configurable latency and a mode that never asserts valid.

## Test plan
- Single job: requester 2, data 00000028_00000000_00000000_00000000, key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, core latency 40 -> core_en high 40 cycles with stable operands, resp_id=2, resp_err=0, resp_data equals model output.
- All four requesters valid continuously, 8 jobs -> grant order 0,1,2,3,0,1,2,3; no req_ready overlap.
- Backpressure: resp_ready low 10 cycles -> resp_valid/data/id held stable, no new grant, core_en low.
- Hung core, TIMEOUT=64 -> core_en high exactly 64 cycles, resp_err=1, resp_data=0; next job then completes normally.
- AES_rst asserted mid-RUN (cycle 20 of 40) -> core_en 0 and busy 0 next cycle, no response; late core valid ignored.
- Valid coincident with watchdog expiry cycle -> resp_err=0, captured data returned.
